// File: rtl/fifo_replay_drain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_replay_drain_pkg                                                    |
// | Shared types and helpers for the replay-FIFO drain stage.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fifo_replay_drain_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        REPLAY = 1'b1
    } state_t;

    // Width needed to count 0..max_out inclusive.
    function automatic int outstanding_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_replay_drain_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_skid2                                                               |
// | Two-entry in-order buffer; simultaneous write and read allowed when full.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_skid2
    import fifo_replay_drain_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    input  logic         ren,
    output logic [W-1:0] rdata,
    output logic         vld,
    output logic [1:0]   cnt
);

    logic [W-1:0] r_mem [2];
    logic         r_head;
    logic [1:0]   r_cnt;
    logic         w_widx;

    // With two entries the tail slot aliases the head; a same-cycle read frees it.
    assign w_widx = r_head ^ r_cnt[0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (ren) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, wen} - {1'b0, ren};
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[w_widx] <= wdata;
        end
    end

    assign rdata = r_mem[r_head];
    assign vld   = (r_cnt != 2'd0);
    assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_replay_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_replay_drain                                                        |
// | Speculative drain for a replay-capable FIFO: go-back-N on consumer nack. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_replay_drain
    import fifo_replay_drain_pkg::*;
#(
    parameter int W       = 32,
    parameter int N       = 16,
    parameter int MAX_OUT = N
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 fifo_empty_r,
    output logic                                 fifo_pop,
    input  logic [W-1:0]                         fifo_pop_data,
    output logic                                 fifo_commit,
    output logic                                 fifo_replay,
    output logic                                 out_vld,
    output logic [W-1:0]                         out_data,
    input  logic                                 out_rdy,
    input  logic                                 resp_vld,
    input  logic                                 resp_ack,
    output logic [outstanding_width(MAX_OUT)-1:0] outstanding_r,
    output logic                                 busy
);

    localparam int c_ow = outstanding_width(MAX_OUT);
    localparam int c_ew = c_ow + 2;

    state_t          r_state;
    logic            r_inflight;
    logic            r_discard;
    logic            r_commit;
    logic            r_replay;

    logic [W-1:0]    w_head;
    logic            w_skid_vld;
    logic [1:0]      w_skid_cnt;
    logic            w_xfer;
    logic            w_resp_ok;
    logic            w_ack;
    logic            w_nack;
    logic            w_pop;
    logic            w_wen;
    logic [2:0]      w_fill;
    logic [c_ew-1:0] w_occ;

    assign w_xfer    = w_skid_vld & out_rdy;
    // A response with nothing outstanding and nothing transferring is dropped.
    assign w_resp_ok = resp_vld & ((outstanding_r != '0) | w_xfer);
    assign w_ack     = w_resp_ok & resp_ack;
    assign w_nack    = w_resp_ok & ~resp_ack;

    assign w_fill = {1'b0, w_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_occ  = c_ew'(outstanding_r) + c_ew'(w_skid_cnt) + c_ew'(r_inflight);

    assign w_pop = (r_state == RUN) & ~fifo_empty_r & ~w_nack
                 & (w_fill < 3'd2) & (w_occ < c_ew'(MAX_OUT));

    assign w_wen = r_inflight & ~r_discard;

    fifo_skid2 #(
        .W (W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (w_nack),
        .wen   (w_wen),
        .wdata (fifo_pop_data),
        .ren   (w_xfer),
        .rdata (w_head),
        .vld   (w_skid_vld),
        .cnt   (w_skid_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_inflight    <= 1'b0;
            r_discard     <= 1'b0;
            r_commit      <= 1'b0;
            r_replay      <= 1'b0;
            outstanding_r <= '0;
        end else begin
            r_inflight <= w_pop;
            r_commit   <= w_ack;
            r_discard  <= w_nack & r_inflight;

            case (r_state)
                RUN: begin
                    if (w_nack) begin
                        r_state  <= REPLAY;
                        r_replay <= 1'b1;
                    end else begin
                        r_replay <= 1'b0;
                    end
                end
                REPLAY: begin
                    r_state  <= RUN;
                    r_replay <= 1'b0;
                end
                default: begin
                    r_state  <= RUN;
                    r_replay <= 1'b0;
                end
            endcase

            // A nack voids everything speculative, including this cycle's transfer.
            if (w_nack) begin
                outstanding_r <= '0;
            end else if (w_xfer && !w_resp_ok) begin
                outstanding_r <= outstanding_r + c_ow'(1);
            end else if (w_resp_ok && !w_xfer) begin
                outstanding_r <= outstanding_r - c_ow'(1);
            end
        end
    end

    assign fifo_pop    = w_pop;
    assign fifo_commit = r_commit;
    assign fifo_replay = r_replay;
    assign out_vld     = w_skid_vld;
    assign out_data    = w_head;
    assign busy        = (r_state != RUN) | w_skid_vld | r_inflight | (outstanding_r != '0);

    a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
        !(resp_vld && (outstanding_r == '0) && !w_xfer));

    a_data_stable : assert property (@(posedge clk) disable iff (rst)
        (out_vld && !out_rdy && !w_nack) |=> $stable(out_data));

endmodule
`default_nettype wire

// File: tb/tb_fifo_replay_drain.sv
`default_nettype none
// Scoreboard bench for fifo_replay_drain: behavioural replay FIFO, in-order
// consumer with scripted ack/nack, and a second instance with MAX_OUT=2.
module tb_fifo_replay_drain;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- instance A (default cap) ----------------
    logic         a_empty, a_pop, a_commit, a_replay, a_vld, a_rdy, a_rv, a_ra, a_busy;
    logic [W-1:0] a_pdata, a_data;
    logic [4:0]   a_outst;

    fifo_replay_drain #(.W(W), .N(16), .MAX_OUT(16)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty_r(a_empty), .fifo_pop(a_pop),
        .fifo_pop_data(a_pdata), .fifo_commit(a_commit), .fifo_replay(a_replay),
        .out_vld(a_vld), .out_data(a_data), .out_rdy(a_rdy),
        .resp_vld(a_rv), .resp_ack(a_ra), .outstanding_r(a_outst), .busy(a_busy)
    );

    // ---------------- instance B (MAX_OUT=2) ----------------
    logic         b_empty, b_pop, b_commit, b_replay, b_vld, b_rdy, b_rv, b_ra, b_busy;
    logic [W-1:0] b_pdata, b_data;
    logic [1:0]   b_outst;

    fifo_replay_drain #(.W(W), .N(16), .MAX_OUT(2)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty_r(b_empty), .fifo_pop(b_pop),
        .fifo_pop_data(b_pdata), .fifo_commit(b_commit), .fifo_replay(b_replay),
        .out_vld(b_vld), .out_data(b_data), .out_rdy(b_rdy),
        .resp_vld(b_rv), .resp_ack(b_ra), .outstanding_r(b_outst), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- replay FIFO model for A ----------------
    logic         push_en;
    logic [W-1:0] push_data;
    logic [W-1:0] fmem [0:255];
    int wp, ap, sp, wn, an, sn, a_pops;

    always_comb begin
        wn = wp + (push_en ? 1 : 0);
        an = ap + (a_commit ? 1 : 0);
        sn = a_replay ? an : sp + (a_pop ? 1 : 0);
    end

    always @(posedge clk) begin
        if (rst) begin
            wp <= 0; ap <= 0; sp <= 0; a_empty <= 1'b1; a_pops <= 0;
        end else begin
            if (push_en) fmem[wp[7:0]] <= push_data;
            if (a_pop) a_pdata <= fmem[sp[7:0]];
            wp <= wn; ap <= an; sp <= sn;
            a_empty <= (sn == wn);
            a_pops <= a_pops + (a_pop ? 1 : 0);
        end
    end

    // ---------------- simple FIFO model for B (no replay needed) ----------------
    int b_cnt = 0;
    int b_sp;
    always @(posedge clk) begin
        if (rst) begin
            b_sp <= 0; b_empty <= 1'b1;
        end else begin
            if (b_pop) b_pdata <= 32'(32'hD0 + b_sp);
            b_sp <= b_sp + (b_pop ? 1 : 0);
            b_empty <= ((b_sp + (b_pop ? 1 : 0)) >= b_cnt);
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int          due;
        logic        ack;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] exp_q [$];
    rsp_t        sched [$];
    int          dly  [0:63];
    logic        ackv [0:63];
    bit          resp_en = 1'b1;
    int cyc = 0;
    int xn, n_xfer, n_commit, n_replay, commit_at_replay, replay_cyc, nack_cyc, max_outst;
    int b_xfers, b_commits;

    // Consumer: answers the oldest transferred entry when its scripted time comes.
    initial begin
        a_rv = 1'b0;
        a_ra = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            a_rv = 1'b0;
            a_ra = 1'b0;
            if (!rst && sched.size() > 0 && sched[0].due <= cyc) begin
                a_rv = 1'b1;
                a_ra = sched[0].ack;
                if (sched[0].ack) begin
                    void'(sched.pop_front());
                end else begin
                    // go-back-N: every unacknowledged entry comes round again in order
                    for (int i = sched.size() - 1; i >= 0; i--) exp_q.push_front(sched[i].data);
                    sched.delete();
                end
            end
        end
    end

    // Monitor: pops and compares on each accepted output, records pulses.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); sched.delete();
            xn = 0; n_xfer = 0; n_commit = 0; n_replay = 0; commit_at_replay = -1;
            replay_cyc = -100; nack_cyc = -200; max_outst = 0; b_xfers = 0; b_commits = 0;
        end else begin
            if (push_en) exp_q.push_back(push_data);
            if (a_commit) n_commit++;
            if (a_replay) begin
                n_replay++;
                replay_cyc = cyc;
                commit_at_replay = n_commit;
            end
            if (int'(a_outst) > max_outst) max_outst = int'(a_outst);
            if (a_rv && !a_ra) nack_cyc = cyc;
            if (a_vld && a_rdy && !(a_rv && !a_ra)) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got %0h expected no transfer", a_data);
                end else begin
                    rsp_t r;
                    chk("a_data", a_data, exp_q.pop_front());
                    if (resp_en) begin
                        r.due  = cyc + dly[xn];
                        r.ack  = ackv[xn];
                        r.data = a_data;
                        sched.push_back(r);
                        if (xn < 63) xn++;
                    end
                end
            end
            if (b_vld && b_rdy) begin
                chk("b_data", b_data, 32'(32'hD0 + b_xfers));
                b_xfers++;
            end
            if (b_commit) b_commits++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic script_default();
        for (int i = 0; i < 64; i++) begin
            dly[i]  = 2;
            ackv[i] = 1'b1;
        end
    endtask

    task automatic push(input logic [31:0] v);
        push_en   = 1'b1;
        push_data = v;
        step(1);
        push_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && sched.size() == 0 && !a_busy && a_empty) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk(name, 32'(ok), 32'd1);
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1; push_en = 1'b0; push_data = '0; a_rdy = 1'b0;
        b_rdy = 1'b0; b_rv = 1'b0; b_ra = 1'b0;
        script_default();

        // Reset state
        do_reset();
        chk("reset_a_outs", {27'd0, a_pop, a_commit, a_replay, a_vld, a_busy}, 32'd0);
        chk("reset_a_outst", 32'(a_outst), 32'd0);
        chk("reset_b_busy", 32'(b_busy), 32'd0);

        // Stream with acks two cycles after each transfer
        a_rdy = 1'b1;
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        wait_drain("stream_drain");
        chk("stream_commits", n_commit, 4);
        chk("stream_peak_outst", max_outst, 2);
        chk("stream_end_outst", 32'(a_outst), 32'd0);
        chk("stream_end_busy", 32'(a_busy), 32'd0);

        // Backpressure
        do_reset();
        a_rdy = 1'b0;
        push(32'hB0); push(32'hB1); push(32'hB2);
        step(5);
        chk("bp_pops", a_pops, 2);
        chk("bp_pop_now", 32'(a_pop), 32'd0);
        chk("bp_vld", 32'(a_vld), 32'd1);
        chk("bp_head", a_data, 32'hB0);
        a_rdy = 1'b1;
        wait_drain("bp_drain");
        chk("bp_commits", n_commit, 3);

        // Nack of C1 while C2 transfers and C3 is in flight
        do_reset();
        script_default();
        dly[0] = 1; ackv[0] = 1'b1;
        dly[1] = 1; ackv[1] = 1'b0;
        a_rdy = 1'b1;
        push(32'hC0); push(32'hC1); push(32'hC2); push(32'hC3);
        wait_drain("nack_drain");
        chk("nack_replays", n_replay, 1);
        chk("nack_replay_lat", replay_cyc - nack_cyc, 1);
        chk("nack_commits_before", commit_at_replay, 1);
        chk("nack_commits", n_commit, 4);
        chk("nack_pops", a_pops, 7);

        // Nack of the only entry: FIFO looks empty until the rewind
        do_reset();
        script_default();
        ackv[0] = 1'b0;
        a_rdy = 1'b1;
        push(32'hE0);
        wait_drain("nack_empty_drain");
        chk("nack_empty_replays", n_replay, 1);
        chk("nack_empty_xfers", n_xfer, 2);
        chk("nack_empty_commits", n_commit, 1);
        chk("nack_empty_pops", a_pops, 2);

        // MAX_OUT=2 instance
        do_reset();
        a_rdy = 1'b0;
        b_cnt = 5;
        b_rdy = 1'b1;
        step(10);
        chk("cap_outst", 32'(b_outst), 32'd2);
        chk("cap_pops", b_sp, 2);
        chk("cap_pop_now", 32'(b_pop), 32'd0);
        chk("cap_vld", 32'(b_vld), 32'd0);
        b_rv = 1'b1; b_ra = 1'b1;
        step(1);
        b_rv = 1'b0; b_ra = 1'b0;
        step(10);
        chk("cap_xfers_after_ack", b_xfers, 3);
        chk("cap_pops_after_ack", b_sp, 3);
        chk("cap_outst_after_ack", 32'(b_outst), 32'd2);
        chk("cap_commits", b_commits, 1);
        chk("cap_no_replay", 32'(b_replay), 32'd0);
        b_rdy = 1'b0;
        b_cnt = 0;

        // Reset mid-stream with skid full and three outstanding
        do_reset();
        resp_en = 1'b0;
        a_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push(32'(32'hF0 + i));
        a_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (a_outst == 5'd3) break;
            step(1);
        end
        a_rdy = 1'b0;
        step(3);
        chk("mid_pre_outst", 32'(a_outst), 32'd3);
        chk("mid_pre_vld", 32'(a_vld), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_vld", 32'(a_vld), 32'd0);
        chk("mid_rst_outst", 32'(a_outst), 32'd0);
        chk("mid_rst_pulses", {29'd0, a_pop, a_commit, a_replay}, 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
